// File: rtl/or16_arbiter_if.sv
// Request/response bus for or16_arbiter: per-requester valid/ready with operands, one shared response.
// With OR16_ARB_STALL_CNT_EN defined the bus also carries the stall counter.
interface or16_arbiter_if #(
   parameter int NREQ = 4,
   parameter int W    = 16
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [W-1:0]      rsp_data;
   logic [IDW-1:0]    rsp_id;
   logic              busy;
`ifdef OR16_ARB_STALL_CNT_EN
   logic [15:0]       stall_cnt;
`endif

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
`ifdef OR16_ARB_STALL_CNT_EN
      output stall_cnt,
`endif
      output req_ready, rsp_valid, rsp_data, rsp_id, busy
   );

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
`ifdef OR16_ARB_STALL_CNT_EN
      input  stall_cnt,
`endif
      input  req_ready, rsp_valid, rsp_data, rsp_id, busy
   );
endinterface

// File: rtl/or16_arbiter.sv
// or16_arbiter: round-robin sharing of one W-bit bitwise-OR datapath among NREQ requesters.
// Build macro OR16_ARB_STALL_CNT_EN adds a saturating count of back-pressured cycles.
module or16_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   or16_arbiter_if.slave bus
);
   localparam int IDW = $clog2(NREQ);

   typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [W-1:0]    rsp_data_q, rsp_data_d;
   logic [IDW-1:0]  rsp_id_q, rsp_id_d;

   logic [IDW:0]    idx_s;
   logic [IDW-1:0]  gnt_id_s;
   logic            gnt_vld_s;
   logic            rsp_valid_s;
   logic            can_accept_s;
   logic            accept_s;
   logic [NREQ-1:0] ready_s;
   logic [W-1:0]    op_a_s, op_b_s;

   assign rsp_valid_s  = (state_q == ST_FULL);
   assign can_accept_s = !rsp_valid_s || bus.rsp_ready;
   assign accept_s     = rst_n && can_accept_s && gnt_vld_s;

   // Round-robin search: first valid requester at or after rr_ptr, wrapping at NREQ.
   always_comb begin
      gnt_vld_s = 1'b0;
      gnt_id_s  = '0;
      idx_s     = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx_s = {1'b0, rr_ptr_q} + (IDW+1)'(k);
         if (idx_s >= (IDW+1)'(NREQ)) begin
            idx_s = idx_s - (IDW+1)'(NREQ);
         end else begin
            idx_s = idx_s;
         end
         if (!gnt_vld_s && bus.req_valid[idx_s[IDW-1:0]]) begin
            gnt_vld_s = 1'b1;
            gnt_id_s  = idx_s[IDW-1:0];
         end else begin
            gnt_vld_s = gnt_vld_s;
         end
      end
   end

   // One-hot ready for the winner and operand mux; ready is held low during reset.
   always_comb begin
      ready_s = '0;
      op_a_s  = '0;
      op_b_s  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_id_s == IDW'(i)) begin
            ready_s[i] = accept_s;
            op_a_s     = bus.req_a[i*W +: W];
            op_b_s     = bus.req_b[i*W +: W];
         end else begin
            ready_s[i] = 1'b0;
         end
      end
   end

   // Next state: an accept reloads the result slot even while it drains, so there is no bubble.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      rsp_data_d = rsp_data_q;
      rsp_id_d   = rsp_id_q;
      if (accept_s) begin
         state_d    = ST_FULL;
         rsp_data_d = op_a_s | op_b_s;
         rsp_id_d   = gnt_id_s;
         if (gnt_id_s == IDW'(NREQ-1)) begin
            rr_ptr_d = '0;
         end else begin
            rr_ptr_d = gnt_id_s + IDW'(1);
         end
      end else if (rsp_valid_s && bus.rsp_ready) begin
         state_d = ST_EMPTY;
      end else begin
         state_d = state_q;
      end
   end

   // Response slot state, round-robin pointer and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_EMPTY;
         rr_ptr_q   <= '0;
         rsp_data_q <= '0;
         rsp_id_q   <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         rsp_data_q <= rsp_data_d;
         rsp_id_q   <= rsp_id_d;
      end
   end

   assign bus.req_ready = ready_s;
   assign bus.rsp_valid = rsp_valid_s;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.busy      = rsp_valid_s;

`ifdef OR16_ARB_STALL_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   // Count cycles a held result is refused, saturating at all-ones.
   always_comb begin
      if (rsp_valid_s && !bus.rsp_ready && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Stall counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= 16'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_or16_arbiter.sv
// Directed bench for or16_arbiter: vector table for steady-state traffic plus hand sequences
// for reset, back-pressure and mid-operation reset.
module tb_or16_arbiter;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   or16_arbiter_if #(.NREQ(4), .W(16)) bus ();

   or16_arbiter #(.NREQ(4), .W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  valid;
      logic [15:0] a;
      logic [15:0] b;
      logic        rr;
      logic [3:0]  exp_ready;
      logic        exp_valid;
      logic [15:0] exp_data;
      logic [1:0]  exp_id;
   } vec_t;

   vec_t tbl [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Real operands go to the requesters in mask, distinctive junk to the rest.
   task automatic set_ops(input logic [3:0] mask, input logic [15:0] a, input logic [15:0] b);
      logic [63:0] av;
      logic [63:0] bv;
      av = '0;
      bv = '0;
      for (int i = 0; i < 4; i++) begin
         if (mask[i]) begin
            av[i*16 +: 16] = a;
            bv[i*16 +: 16] = b;
         end else begin
            av[i*16 +: 16] = 16'hC300 | 16'(i);
            bv[i*16 +: 16] = 16'h00C0;
         end
      end
      bus.req_a = av;
      bus.req_b = bv;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.req_valid = 4'b0000;
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;

      tbl[0]  = '{4'b1111, 16'h0F00, 16'h00F0, 1'b1, 4'b0001, 1'b1, 16'h0FF0, 2'd0};
      tbl[1]  = '{4'b1111, 16'h0F00, 16'h00F0, 1'b1, 4'b0010, 1'b1, 16'h0FF0, 2'd1};
      tbl[2]  = '{4'b1111, 16'h0F00, 16'h00F0, 1'b1, 4'b0100, 1'b1, 16'h0FF0, 2'd2};
      tbl[3]  = '{4'b1111, 16'h0F00, 16'h00F0, 1'b1, 4'b1000, 1'b1, 16'h0FF0, 2'd3};
      tbl[4]  = '{4'b1111, 16'h0F00, 16'h00F0, 1'b1, 4'b0001, 1'b1, 16'h0FF0, 2'd0};
      tbl[5]  = '{4'b0100, 16'hFFFF, 16'h0000, 1'b1, 4'b0100, 1'b1, 16'hFFFF, 2'd2};
      tbl[6]  = '{4'b0010, 16'hAAAA, 16'h5555, 1'b1, 4'b0010, 1'b1, 16'hFFFF, 2'd1};
      tbl[7]  = '{4'b1000, 16'h0000, 16'h0000, 1'b1, 4'b1000, 1'b1, 16'h0000, 2'd3};
      tbl[8]  = '{4'b1001, 16'h1200, 16'h0034, 1'b1, 4'b0001, 1'b1, 16'h1234, 2'd0};
      tbl[9]  = '{4'b1001, 16'h1200, 16'h0034, 1'b1, 4'b1000, 1'b1, 16'h1234, 2'd3};
      tbl[10] = '{4'b1001, 16'h1200, 16'h0034, 1'b1, 4'b0001, 1'b1, 16'h1234, 2'd0};
      tbl[11] = '{4'b1001, 16'h1200, 16'h0034, 1'b1, 4'b1000, 1'b1, 16'h1234, 2'd3};
      tbl[12] = '{4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0};
      tbl[13] = '{4'b0010, 16'h00A0, 16'h000B, 1'b0, 4'b0010, 1'b1, 16'h00AB, 2'd1};
      tbl[14] = '{4'b0100, 16'h0000, 16'h0000, 1'b0, 4'b0000, 1'b1, 16'h00AB, 2'd1};
      tbl[15] = '{4'b0100, 16'h5000, 16'h0005, 1'b1, 4'b0100, 1'b1, 16'h5005, 2'd2};

      // Reset state with all requesters asking
      rst_n = 1'b0;
      bus.req_valid = 4'b1111;
      bus.rsp_ready = 1'b1;
      set_ops(4'b0000, 16'h0000, 16'h0000);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      chk("rst_rsp_data", 32'(bus.rsp_data), 32'h0);
      chk("rst_rsp_id", 32'(bus.rsp_id), 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
`ifdef OR16_ARB_STALL_CNT_EN
      chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'h0);
`endif

      // Single request right after reset release
      rst_n = 1'b1;
      bus.req_valid = 4'b0001;
      set_ops(4'b0001, 16'h0001, 16'h0000);
      #2;
      chk("single_ready", 32'(bus.req_ready), 32'h1);
      @(posedge clk);
      #1;
      chk("single_valid", 32'(bus.rsp_valid), 32'h1);
      chk("single_data", 32'(bus.rsp_data), 32'h0001);
      chk("single_id", 32'(bus.rsp_id), 32'h0);

      do_reset();
      for (int r = 0; r < 16; r++) begin
         bus.req_valid = tbl[r].valid;
         bus.rsp_ready = tbl[r].rr;
         set_ops(tbl[r].exp_ready, tbl[r].a, tbl[r].b);
         #2;
         chk($sformatf("vec%0d_ready", r), 32'(bus.req_ready), 32'(tbl[r].exp_ready));
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_valid", r), 32'(bus.rsp_valid), 32'(tbl[r].exp_valid));
         chk($sformatf("vec%0d_busy", r), 32'(bus.busy), 32'(tbl[r].exp_valid));
         if (tbl[r].exp_valid) begin
            chk($sformatf("vec%0d_data", r), 32'(bus.rsp_data), 32'(tbl[r].exp_data));
            chk($sformatf("vec%0d_id", r), 32'(bus.rsp_id), 32'(tbl[r].exp_id));
         end
      end

      // Back-pressure: hold a result for 5 cycles, pointer must not move
      do_reset();
      bus.req_valid = 4'b0100;
      bus.rsp_ready = 1'b0;
      set_ops(4'b0100, 16'h1200, 16'h0034);
      #2;
      chk("bp_accept_ready", 32'(bus.req_ready), 32'h4);
      @(posedge clk);
      #1;
      chk("bp_accept_data", 32'(bus.rsp_data), 32'h1234);
      bus.req_valid = 4'b1111;
      set_ops(4'b0000, 16'h0000, 16'h0000);
      for (int c = 0; c < 5; c++) begin
         #2;
         chk($sformatf("bp%0d_ready", c), 32'(bus.req_ready), 32'h0);
         @(posedge clk);
         #1;
         chk($sformatf("bp%0d_valid", c), 32'(bus.rsp_valid), 32'h1);
         chk($sformatf("bp%0d_data", c), 32'(bus.rsp_data), 32'h1234);
         chk($sformatf("bp%0d_id", c), 32'(bus.rsp_id), 32'h2);
      end
`ifdef OR16_ARB_STALL_CNT_EN
      chk("bp_stall_cnt", 32'(bus.stall_cnt), 32'd5);
`endif
      bus.rsp_ready = 1'b1;
      set_ops(4'b1000, 16'h00FF, 16'hFF00);
      #2;
      chk("bp_release_ready", 32'(bus.req_ready), 32'h8);
      @(posedge clk);
      #1;
      chk("bp_release_id", 32'(bus.rsp_id), 32'h3);
      chk("bp_release_data", 32'(bus.rsp_data), 32'hFFFF);

      // Reset while a result is stalled
      bus.req_valid = 4'b0000;
      bus.rsp_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_pre_valid", 32'(bus.rsp_valid), 32'h1);
      bus.req_valid = 4'b0110;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(bus.rsp_valid), 32'h0);
      chk("mid_rst_busy", 32'(bus.busy), 32'h0);
      chk("mid_rst_ready", 32'(bus.req_ready), 32'h0);
`ifdef OR16_ARB_STALL_CNT_EN
      chk("mid_rst_stall_cnt", 32'(bus.stall_cnt), 32'h0);
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.rsp_ready = 1'b1;
      set_ops(4'b0010, 16'h0A00, 16'h000A);
      #2;
      chk("mid_after_ready", 32'(bus.req_ready), 32'h2);
      @(posedge clk);
      #1;
      chk("mid_after_valid", 32'(bus.rsp_valid), 32'h1);
      chk("mid_after_id", 32'(bus.rsp_id), 32'h1);
      chk("mid_after_data", 32'(bus.rsp_data), 32'h0A0A);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
